// File: rtl/led_pkg.sv
// Shared parameters and helpers for the LED fade/PWM driver.
// Imported by the top and the per-channel fade module.
package led_pkg;

  localparam int LEDS_DEF      = 8;
  localparam int PWM_W_DEF     = 4;
  localparam int DECAY_DIV_DEF = 16;

  function automatic int lvl_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/led_fade_chan.sv
// One LED channel: brightness level with priority update,
// plus a registered PWM comparator driving the pin.
module led_fade_chan
  import led_pkg::*;
#(
  parameter int PWM_W = PWM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             pat_i,
  input  logic             tick_i,
  input  logic [PWM_W-1:0] cnt_i,
  output logic             led_o
);

  localparam logic [PWM_W-1:0] LMAX = PWM_W'(lvl_max(PWM_W));

  logic [PWM_W-1:0] lvl_q, lvl_d;
  logic             led_q, led_d;

  // A set pattern bit outranks a decay tick on the same clk.
  always_comb begin
    lvl_d = lvl_q;
    if (!enable_i) begin
      lvl_d = '0;
    end else if (pat_i) begin
      lvl_d = LMAX;
    end else if (tick_i && (lvl_q != '0)) begin
      lvl_d = lvl_q - 1'b1;
    end
  end

  always_comb begin
    led_d = enable_i & ((lvl_q == LMAX) | (cnt_i < lvl_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_q <= '0;
      led_q <= 1'b0;
    end else begin
      lvl_q <= lvl_d;
      led_q <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/led_fade_pwm.sv
// LED bar driver: shared PWM/frame/decay timing and
// one fade channel per LED.
module led_fade_pwm
  import led_pkg::*;
#(
  parameter int LEDS      = LEDS_DEF,
  parameter int PWM_W     = PWM_W_DEF,
  parameter int DECAY_DIV = DECAY_DIV_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [LEDS-1:0] pattern,
  output logic [LEDS-1:0] led,
  output logic            frame
);

  localparam logic [PWM_W-1:0] LMAX = PWM_W'(lvl_max(PWM_W));
  localparam int DW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [DW-1:0] DLAST = DW'(DECAY_DIV - 1);

  logic [PWM_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic             frame_q, frame_d;
  logic             decay_tick;

  always_comb begin
    cnt_d   = '0;
    frame_d = 1'b0;
    dcnt_d  = '0;
    if (enable) begin
      cnt_d   = cnt_q + 1'b1;
      frame_d = (cnt_q == LMAX);
      dcnt_d  = dcnt_q;
      if (frame_q) begin
        dcnt_d = (dcnt_q == DLAST) ? '0 : dcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      dcnt_q  <= '0;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      frame_q <= frame_d;
    end
  end

  assign decay_tick = frame_q & (dcnt_q == DLAST);
  assign frame      = frame_q;

  for (genvar i = 0; i < LEDS; i++) begin : g_ch
    led_fade_chan #(
      .PWM_W(PWM_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .enable_i(enable),
      .pat_i   (pattern[i]),
      .tick_i  (decay_tick),
      .cnt_i   (cnt_q),
      .led_o   (led[i])
    );
  end

endmodule
